// File: rtl/load_store_unit.sv
// Load/store unit: turns core byte/half/word requests into word accesses on a
// word-organised data memory, with read-modify-write for sub-word stores.
package load_store_unit_pkg;
  localparam int unsigned DATA_32_W = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } size_e;
endpackage

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DATA_MEM_DEPTH = 16,
  parameter int unsigned ADDR_W         = $clog2(DATA_MEM_DEPTH) + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_32_W-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [DATA_32_W-1:0] resp_rdata,
  output logic                 resp_err,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_we,
  output logic [DATA_32_W-1:0] mem_wdata,
  input  logic [DATA_32_W-1:0] mem_rdata
);

  localparam int unsigned ADDR_LIMIT = DATA_MEM_DEPTH * 4;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ST_WORD, S_ST_RD, S_ST_WR, S_DONE
  } state_e;

  state_e                r_state;
  size_e                 r_size;
  logic [1:0]            r_lane;
  logic                  r_signed;
  logic [DATA_32_W-1:0]  r_wdata;
  logic [DATA_32_W-1:0]  r_merge;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic [DATA_32_W-1:0]  r_resp_rdata;
  logic                  r_resp_err;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic                  r_mem_we;

  logic                  w_accept;
  logic                  w_out_of_range;
  logic                  w_err;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_32_W-1:0]  w_load;
  logic [DATA_32_W-1:0]  w_wr_word;

  assign w_accept       = req_valid & r_req_ready;
  assign w_out_of_range = (32'(req_addr) >= ADDR_LIMIT);
  assign w_err = (req_size == SIZE_BAD)
               | ((req_size == SIZE_HALF) & req_addr[0])
               | ((req_size == SIZE_WORD) & (req_addr[1:0] != 2'b00))
               | w_out_of_range;

  // Little-endian lane select and sign/zero extension of the loaded word
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_lane)
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      SIZE_BYTE: w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      SIZE_HALF: w_load = {{16{r_signed & w_half[15]}}, w_half};
      default:   w_load = mem_rdata;
    endcase
  end

  // Write word: full store data, or the merge word with one lane replaced
  always_comb begin
    w_wr_word = r_merge;
    case (r_size)
      SIZE_BYTE: begin
        case (r_lane)
          2'd1:    w_wr_word[15:8]  = r_wdata[7:0];
          2'd2:    w_wr_word[23:16] = r_wdata[7:0];
          2'd3:    w_wr_word[31:24] = r_wdata[7:0];
          default: w_wr_word[7:0]   = r_wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (r_lane[1]) w_wr_word[31:16] = r_wdata[15:0];
        else           w_wr_word[15:0]  = r_wdata[15:0];
      end
      default: w_wr_word = r_wdata;
    endcase
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_addr   = r_mem_addr;
  assign mem_we     = r_mem_we;
  assign mem_wdata  = r_mem_we ? w_wr_word : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_size       <= SIZE_BYTE;
      r_lane       <= 2'b00;
      r_signed     <= 1'b0;
      r_wdata      <= '0;
      r_merge      <= '0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_mem_we     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_size      <= size_e'(req_size);
            r_lane      <= req_addr[1:0];
            r_signed    <= req_signed;
            r_wdata     <= req_wdata;
            if (w_err) begin
              r_state      <= S_DONE;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= '0;
              r_resp_err   <= 1'b1;
            end else begin
              r_mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
              if (!req_write) begin
                r_state <= S_LOAD;
              end else if (size_e'(req_size) == SIZE_WORD) begin
                r_state  <= S_ST_WORD;
                r_mem_we <= 1'b1;
              end else begin
                r_state <= S_ST_RD;
              end
            end
          end
        end
        S_LOAD: begin
          r_state      <= S_DONE;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_load;
          r_resp_err   <= 1'b0;
        end
        S_ST_RD: begin
          r_state  <= S_ST_WR;
          r_merge  <= mem_rdata;
          r_mem_we <= 1'b1;
        end
        S_ST_WORD, S_ST_WR: begin
          r_state      <= S_DONE;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected
// responses; a negedge monitor checks data, error, latency and memory writes.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int unsigned DEPTH = 16;
  // One extra address bit so that addresses past the memory can be issued
  localparam int unsigned AW    = 7;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we_cnt;
    logic [31:0] wdata;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_signed = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0]   mem [DEPTH];
  logic [4:0]    w_idx;

  exp_t sb_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   we_seen = 0;

  load_store_unit #(.DATA_MEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, synchronous write
  assign w_idx     = mem_addr[AW-1:2];
  assign mem_rdata = w_idx[4] ? 32'h0 : mem[w_idx[3:0]];
  always @(posedge clk) if (mem_we && !w_idx[4]) mem[w_idx[3:0]] <= mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && req_valid && req_ready) acc_q.push_back(cyc);
  end

  // Monitor: memory-write and response checking against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (!rst) begin
      chk("we_in_reset", {31'b0, mem_we}, 32'h0);
      we_seen = 0;
    end else begin
      if (mem_we) begin
        we_seen++;
        chk("mem_wdata", mem_wdata, (sb_q.size() != 0) ? sb_q[0].wdata : 32'hxxxx_xxxx);
      end
      if (resp_valid) begin
        if (sb_q.size() == 0 || acc_q.size() == 0) begin
          chk("unexpected_resp", {31'b0, resp_valid}, 32'h0);
        end else begin
          e = sb_q.pop_front();
          a = acc_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          chk("latency", 32'(cyc - a), 32'(e.lat));
          chk("we_cycles", 32'(we_seen), 32'(e.we_cnt));
        end
        we_seen = 0;
      end
    end
  end

  task automatic push_exp(input logic [31:0] e_rd, input logic e_err, input int e_lat,
                          input int e_we, input logic [31:0] e_wd);
    exp_t e;
    e.rdata = e_rd; e.err = e_err; e.lat = e_lat; e.we_cnt = e_we; e.wdata = e_wd;
    sb_q.push_back(e);
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) chk({nm, "_ready_timeout"}, {31'b0, req_ready}, 32'h1);
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [AW-1:0] ad, input logic [31:0] wd,
                       input logic [31:0] e_rd, input logic e_err, input int e_lat,
                       input int e_we, input logic [31:0] e_wd);
    int n = 0;
    push_exp(e_rd, e_err, e_lat, e_we, e_wd);
    @(negedge clk);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
    req_valid = 1'b1;
    wait_ready("issue");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = 32'hA5A5_A5A5;
    req_addr  = 7'h15;
    while (sb_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (sb_q.size() != 0) begin
      chk("resp_timeout", 32'(sb_q.size()), 32'h0);
      sb_q.delete();
      acc_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_prev;
    int t_acc;
    logic [AW-1:0] b2b_addr [3];
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'h0);
    chk("rst_flags", {29'b0, resp_valid, resp_err, mem_we}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, req_ready}, 32'h1);

    // Word store/load and sub-word loads of 0xDEADBEEF
    issue(1'b1, 2'b10, 1'b0, 7'h08, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 7'h08, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 7'h0B, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 0, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 7'h09, 32'h0, 32'h000000BE, 1'b0, 2, 0, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 7'h0A, 32'h0, 32'hFFFFDEAD, 1'b0, 2, 0, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 7'h08, 32'h0, 32'h0000BEEF, 1'b0, 2, 0, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 7'h08, 32'h0, 32'hFFFFFFEF, 1'b0, 2, 0, 32'h0);

    // Read-modify-write sub-word stores
    issue(1'b1, 2'b00, 1'b0, 7'h09, 32'hFFFFFF12, 32'h0, 1'b0, 3, 1, 32'hDEAD12EF);
    issue(1'b0, 2'b10, 1'b0, 7'h08, 32'h0, 32'hDEAD12EF, 1'b0, 2, 0, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 7'h0A, 32'h5555ABCD, 32'h0, 1'b0, 3, 1, 32'hABCD12EF);
    issue(1'b1, 2'b10, 1'b0, 7'h00, 32'h11223344, 32'h0, 1'b0, 2, 1, 32'h11223344);
    issue(1'b1, 2'b10, 1'b0, 7'h04, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1, 32'hCAFEF00D);
    issue(1'b1, 2'b00, 1'b1, 7'h07, 32'h00000080, 32'h0, 1'b0, 3, 1, 32'h80FEF00D);
    issue(1'b0, 2'b00, 1'b1, 7'h07, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 7'h06, 32'h0, 32'h000080FE, 1'b0, 2, 0, 32'h0);

    // Error cases: misaligned, out of range, illegal size
    issue(1'b1, 2'b01, 1'b0, 7'h05, 32'h0000FFFF, 32'h0, 1'b1, 1, 0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 7'h40, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 7'h40, 32'h000000EE, 32'h0, 1'b1, 1, 0, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 7'h00, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 7'h0A, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 7'h03, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 7'h00, 32'h0, 32'h11223344, 1'b0, 2, 0, 32'h0);

    // Last word of memory is in range
    issue(1'b1, 2'b10, 1'b0, 7'h3C, 32'h0BADF00D, 32'h0, 1'b0, 2, 1, 32'h0BADF00D);
    issue(1'b0, 2'b00, 1'b1, 7'h3F, 32'h0, 32'h0000000B, 1'b0, 2, 0, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 7'h3E, 32'h0, 32'hFFFFFFAD, 1'b0, 2, 0, 32'h0);

    // Back-to-back word loads with req_valid held high
    b2b_addr[0] = 7'h00; b2b_addr[1] = 7'h04; b2b_addr[2] = 7'h08;
    push_exp(32'h11223344, 1'b0, 2, 0, 32'h0);
    push_exp(32'h80FEF00D, 1'b0, 2, 0, 32'h0);
    push_exp(32'hABCD12EF, 1'b0, 2, 0, 32'h0);
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = b2b_addr[0];
    req_valid = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      wait_ready("b2b");
      @(posedge clk);
      #1;
      t_acc = cyc;
      if (i > 0) chk("b2b_spacing", 32'(t_acc - t_prev), 32'd3);
      t_prev = t_acc;
      if (i < 2) req_addr = b2b_addr[i + 1];
      else       req_valid = 1'b0;
      @(negedge clk);
      chk("b2b_ready_load", {31'b0, req_ready}, 32'h0);
      @(negedge clk);
      chk("b2b_ready_done", {31'b0, req_ready}, 32'h0);
      @(negedge clk);
      chk("b2b_ready_idle", {31'b0, req_ready}, 32'h1);
    end
    chk("b2b_drained", 32'(sb_q.size()), 32'h0);

    // Reset while a byte store sits in ST_RD
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 7'h08;
    req_wdata = 32'h00000077; req_valid = 1'b1;
    wait_ready("rst_store");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b0;
    sb_q.delete();
    acc_q.delete();
    @(negedge clk);
    chk("abort_flags", {28'b0, req_ready, resp_valid, resp_err, mem_we}, 32'h0);
    chk("abort_mem_wdata", mem_wdata, 32'h0);
    chk("abort_mem_addr", 32'(mem_addr), 32'h0);
    chk("abort_rdata", resp_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", {31'b0, req_ready}, 32'h1);
    issue(1'b0, 2'b10, 1'b0, 7'h08, 32'h0, 32'hABCD12EF, 1'b0, 2, 0, 32'h0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
